// File: rtl/spi_flash_fetch.sv
// Read-sequencing master for the spi register port: configures the spi block, then turns
// byte-read requests into CMD / 3-byte address / dummy-clocked data flash READ sequences.
module spi_flash_fetch #(
  parameter logic [1:0] CS_SEL   = 2'd0,
  parameter logic       SPI_SRC  = 1'b0,
  parameter logic [1:0] SPI_MODE = 2'd0,
  parameter logic [6:0] CLK_DIV  = 7'd1,
  parameter logic [7:0] CMD      = 8'h03,
  parameter logic [7:0] DUMMY    = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  input  logic [3:0]  i_req_len,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_last,
  output logic        o_busy,
  output logic [2:0]  o_spi_reg_addr,
  output logic [1:0]  o_spi_reg_sel,
  output logic [7:0]  o_spi_reg_data,
  output logic        o_spi_reg_write,
  output logic        o_spi_reg_read,
  input  logic [7:0]  i_spi_data_in,
  input  logic        i_spi_interrupt
);

  localparam int unsigned LEN_W = 5;

  typedef enum logic [3:0] {
    S_INIT_MODE = 4'd0,
    S_INIT_DIV  = 4'd1,
    S_IDLE      = 4'd2,
    S_CMD       = 4'd3,
    S_WAIT      = 4'd4,
    S_ADDR      = 4'd5,
    S_DSTART    = 4'd6,
    S_DWAIT     = 4'd7,
    S_HOLD      = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [23:0]        r_addr;
  logic [1:0]         r_idx;
  logic [LEN_W-1:0]   r_remain;
  logic               r_rd_valid;
  logic               r_rd_last;
  logic [7:0]         r_rd_data;
  logic               w_accept;
  logic               w_byte_done;
  logic               w_last_byte;
  logic               w_handshake;

  assign w_accept    = (r_state == S_IDLE) && i_req_valid;
  assign w_byte_done = (r_state == S_DWAIT) && i_spi_interrupt;
  assign w_last_byte = (r_remain == LEN_W'(1));
  assign w_handshake = (r_state == S_HOLD) && i_rd_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_INIT_MODE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT_MODE: w_next_state = S_INIT_DIV;
      S_INIT_DIV:  w_next_state = S_IDLE;
      S_IDLE:      if (i_req_valid) w_next_state = S_CMD;
      S_CMD:       w_next_state = S_WAIT;
      S_WAIT:      if (i_spi_interrupt) w_next_state = (r_idx == 2'd3) ? S_DSTART : S_ADDR;
      S_ADDR:      w_next_state = S_WAIT;
      S_DSTART:    w_next_state = S_DWAIT;
      S_DWAIT:     if (i_spi_interrupt) w_next_state = S_HOLD;
      S_HOLD:      if (i_rd_ready) w_next_state = w_last_byte ? S_IDLE : S_DSTART;
      default:     w_next_state = S_INIT_MODE;
    endcase
  end

  // Register-port strobes; reset masks them so nothing reaches the spi block while it resets
  always_comb begin
    o_spi_reg_write = 1'b0;
    o_spi_reg_read  = 1'b0;
    o_spi_reg_addr  = 3'd0;
    o_spi_reg_data  = 8'd0;
    o_busy          = 1'b1;
    o_req_ready     = 1'b0;
    case (r_state)
      S_INIT_MODE: begin
        o_spi_reg_write = 1'b1;
        o_spi_reg_addr  = 3'd4;
        o_spi_reg_data  = {5'b0, SPI_SRC, SPI_MODE};
      end
      S_INIT_DIV: begin
        o_spi_reg_write = 1'b1;
        o_spi_reg_addr  = 3'd5;
        o_spi_reg_data  = {1'b0, CLK_DIV};
      end
      S_IDLE: begin
        o_busy      = 1'b0;
        o_req_ready = 1'b1;
      end
      S_CMD: begin
        o_spi_reg_write = 1'b1;
        o_spi_reg_addr  = 3'd0;
        o_spi_reg_data  = CMD;
      end
      S_ADDR: begin
        o_spi_reg_write = 1'b1;
        o_spi_reg_addr  = 3'd1;
        case (r_idx)
          2'd0:    o_spi_reg_data = r_addr[23:16];
          2'd1:    o_spi_reg_data = r_addr[15:8];
          default: o_spi_reg_data = r_addr[7:0];
        endcase
      end
      S_DSTART: begin
        o_spi_reg_write = 1'b1;
        o_spi_reg_addr  = 3'd1;
        o_spi_reg_data  = DUMMY;
      end
      S_DWAIT: begin
        // Final byte is read through addr 0 so the same access also closes the transaction
        o_spi_reg_read = i_spi_interrupt;
        o_spi_reg_addr = w_last_byte ? 3'd0 : 3'd1;
      end
      default: ;
    endcase
    if (i_reset) begin
      o_spi_reg_write = 1'b0;
      o_spi_reg_read  = 1'b0;
      o_busy          = 1'b1;
      o_req_ready     = 1'b0;
    end
  end

  // Request latch, address index, byte countdown and output byte holding register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= 24'd0;
      r_idx      <= 2'd0;
      r_remain   <= LEN_W'(0);
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_req_addr;
        r_remain <= (i_req_len == 4'd0) ? LEN_W'(16) : LEN_W'(i_req_len);
      end
      if (r_state == S_CMD)  r_idx <= 2'd0;
      if (r_state == S_ADDR) r_idx <= r_idx + 2'd1;
      if (w_byte_done) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= i_spi_data_in;
        r_rd_last  <= w_last_byte;
      end
      if (w_handshake) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
        r_remain   <= r_remain - LEN_W'(1);
      end
    end
  end

  assign o_spi_reg_sel = CS_SEL;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_rd_last     = r_rd_last;

endmodule

// File: tb/tb_spi_flash_fetch.sv
// Bench for spi_flash_fetch: a behavioural spi register-port model with a flash data pattern,
// directed request scenarios, and per-scenario inline checks.
module tb_spi_flash_fetch;

  localparam int BYTE_T = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [3:0]  req_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        busy;
  logic [2:0]  spi_reg_addr;
  logic [1:0]  spi_reg_sel;
  logic [7:0]  spi_reg_data;
  logic        spi_reg_write;
  logic        spi_reg_read;
  logic [7:0]  spi_data_in;
  logic        spi_interrupt;

  int total = 0;
  int bad   = 0;

  // spi model state
  logic        m_cs_n;
  logic        m_irq;
  int          m_cnt;
  int          m_byte_no;
  logic [23:0] m_addr;
  logic [7:0]  m_rx;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_rd0 = 0;
  int          n_rd1 = 0;
  int          proto_err = 0;
  int          w_err;
  logic        last_acc_rd = 1'b0;
  logic [2:0]  last_acc_addr = 3'd7;

  logic [7:0]  mosi_q[$];
  logic [2:0]  cfg_a_q[$];
  logic [7:0]  cfg_d_q[$];
  logic [7:0]  beat_data_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int          acc_cyc_q[$];

  spi_flash_fetch dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_addr      (req_addr),
    .i_req_len       (req_len),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_rd_data       (rd_data),
    .o_rd_last       (rd_last),
    .o_busy          (busy),
    .o_spi_reg_addr  (spi_reg_addr),
    .o_spi_reg_sel   (spi_reg_sel),
    .o_spi_reg_data  (spi_reg_data),
    .o_spi_reg_write (spi_reg_write),
    .o_spi_reg_read  (spi_reg_read),
    .i_spi_data_in   (spi_data_in),
    .i_spi_interrupt (spi_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hF3;
  endfunction

  assign spi_data_in   = m_rx;
  assign spi_interrupt = m_irq;

  // Register-port protocol violations seen by the spi side
  always_comb begin
    w_err = 0;
    if (!reset) begin
      if (spi_reg_write && spi_reg_read) w_err++;
      if ((spi_reg_write || spi_reg_read) && spi_reg_sel != 2'd0) w_err++;
      if (spi_reg_write && spi_reg_addr <= 3'd1 && m_cnt != 0) w_err++;
      if (spi_reg_write && spi_reg_addr == 3'd1 && m_cs_n) w_err++;
      if (spi_reg_write && spi_reg_addr != 3'd0 && spi_reg_addr != 3'd1 &&
          spi_reg_addr != 3'd4 && spi_reg_addr != 3'd5) w_err++;
      if (spi_reg_read && (m_cnt != 0 || !m_irq || m_cs_n)) w_err++;
      if (spi_reg_read && spi_reg_addr > 3'd1) w_err++;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_cs_n    <= 1'b1;
      m_irq     <= 1'b0;
      m_cnt     <= 0;
      m_byte_no <= 0;
      m_addr    <= 24'd0;
      m_rx      <= 8'd0;
    end else begin
      proto_err <= proto_err + w_err;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_irq <= 1'b1;
      end
      if (spi_reg_write) begin
        n_wr          <= n_wr + 1;
        last_acc_rd   <= 1'b0;
        last_acc_addr <= spi_reg_addr;
        if (spi_reg_addr == 3'd4 || spi_reg_addr == 3'd5) begin
          cfg_a_q.push_back(spi_reg_addr);
          cfg_d_q.push_back(spi_reg_data);
        end else if (spi_reg_addr <= 3'd1) begin
          mosi_q.push_back(spi_reg_data);
          m_irq <= 1'b0;
          m_cnt <= BYTE_T;
          if (spi_reg_addr == 3'd0) begin
            m_cs_n    <= 1'b0;
            m_byte_no <= 1;
          end else begin
            if (m_byte_no >= 1 && m_byte_no <= 3) m_addr <= {m_addr[15:0], spi_reg_data};
            else if (m_byte_no >= 4) m_rx <= flash_byte(m_addr + 24'(m_byte_no - 4));
            m_byte_no <= m_byte_no + 1;
          end
        end
      end
      if (spi_reg_read) begin
        last_acc_rd   <= 1'b1;
        last_acc_addr <= spi_reg_addr;
        if (spi_reg_addr == 3'd0) begin
          n_rd0  <= n_rd0 + 1;
          m_cs_n <= 1'b1;
        end else begin
          n_rd1 <= n_rd1 + 1;
        end
      end
    end
  end

  // Stream and request handshake log
  always @(posedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      beat_data_q.push_back(rd_data);
      beat_last_q.push_back(rd_last);
      beat_cyc_q.push_back(cyc);
    end
    if (!reset && req_valid && req_ready) acc_cyc_q.push_back(cyc);
  end

  task automatic clear_logs();
    mosi_q.delete();
    cfg_a_q.delete();
    cfg_d_q.delete();
    beat_data_q.delete();
    beat_last_q.delete();
    beat_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = (req_ready !== 1'b1);
  endtask

  task automatic issue(input logic [23:0] a, input logic [3:0] l, output bit to);
    int n;
    n = 0;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    to = (req_ready !== 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit to;
    int wr0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 24'd0;
    req_len   = 4'd0;
    rd_ready  = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, busy, rd_valid, rd_last, spi_reg_write, spi_reg_read} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_vals got=%b exp=010000",
               {req_ready, busy, rd_valid, rd_last, spi_reg_write, spi_reg_read});
    end
    clear_logs();
    wr0   = n_wr;
    reset = 1'b0;
    wait_idle(200, to);
    total++;
    if (to) begin bad++; $display("FAIL reset_idle_timeout got=1 exp=0"); end
    total++;
    if (n_wr - wr0 != 2 || cfg_a_q.size() != 2) begin
      bad++;
      $display("FAIL reset_wr_count got=%0d exp=2", n_wr - wr0);
    end else begin
      total++;
      if (cfg_a_q[0] !== 3'd4 || cfg_d_q[0] !== 8'h00) begin
        bad++;
        $display("FAIL reset_wr_mode got=%0d/%h exp=4/00", cfg_a_q[0], cfg_d_q[0]);
      end
      total++;
      if (cfg_a_q[1] !== 3'd5 || cfg_d_q[1] !== 8'h01) begin
        bad++;
        $display("FAIL reset_wr_div got=%0d/%h exp=5/01", cfg_a_q[1], cfg_d_q[1]);
      end
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_flags got=%b%b exp=10", req_ready, busy);
    end
  endtask

  task automatic test_single_byte();
    bit to;
    int r0, r1;
    logic [7:0] exp_m [5];
    exp_m[0] = 8'h03; exp_m[1] = 8'h12; exp_m[2] = 8'h34; exp_m[3] = 8'h56; exp_m[4] = 8'hFF;
    clear_logs();
    r0 = n_rd0; r1 = n_rd1;
    rd_ready = 1'b1;
    issue(24'h123456, 4'd1, to);
    wait_idle(500, to);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
    total++;
    if (mosi_q.size() != 5) begin
      bad++;
      $display("FAIL single_mosi_len got=%0d exp=5", mosi_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (mosi_q[i] !== exp_m[i]) begin
          bad++;
          $display("FAIL single_mosi[%0d] got=%h exp=%h", i, mosi_q[i], exp_m[i]);
        end
      end
    end
    total++;
    if (last_acc_rd !== 1'b1 || last_acc_addr !== 3'd0 || m_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL single_end got=rd%b addr%0d cs_n%b exp=rd1 addr0 cs_n1",
               last_acc_rd, last_acc_addr, m_cs_n);
    end
    total++;
    if (n_rd0 - r0 != 1 || n_rd1 - r1 != 0) begin
      bad++;
      $display("FAIL single_reads got=%0d/%0d exp=1/0", n_rd0 - r0, n_rd1 - r1);
    end
    total++;
    if (beat_data_q.size() != 1) begin
      bad++;
      $display("FAIL single_beats got=%0d exp=1", beat_data_q.size());
    end else begin
      total++;
      if (beat_data_q[0] !== 8'hA5 || beat_last_q[0] !== 1'b1) begin
        bad++;
        $display("FAIL single_beat got=%h/%b exp=a5/1", beat_data_q[0], beat_last_q[0]);
      end
    end
  endtask

  task automatic test_len16();
    bit to;
    int r0, r1;
    logic [23:0] a;
    a = 24'h0010F8;
    clear_logs();
    r0 = n_rd0; r1 = n_rd1;
    issue(a, 4'd0, to);
    wait_idle(3000, to);
    total++;
    if (to) begin bad++; $display("FAIL len16_timeout got=1 exp=0"); end
    total++;
    if (beat_data_q.size() != 16) begin
      bad++;
      $display("FAIL len16_beats got=%0d exp=16", beat_data_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (beat_data_q[i] !== flash_byte(a + 24'(i)) || beat_last_q[i] !== (i == 15)) begin
          bad++;
          $display("FAIL len16_beat[%0d] got=%h/%b exp=%h/%b", i, beat_data_q[i],
                   beat_last_q[i], flash_byte(a + 24'(i)), (i == 15));
        end
      end
    end
    total++;
    if (n_rd1 - r1 != 15 || n_rd0 - r0 != 1) begin
      bad++;
      $display("FAIL len16_reads got=%0d/%0d exp=15/1", n_rd1 - r1, n_rd0 - r0);
    end
    total++;
    if (mosi_q.size() != 20) begin
      bad++;
      $display("FAIL len16_mosi_len got=%0d exp=20", mosi_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit data_moved, cs_rose, valid_fell;
    int n, wr0;
    logic [7:0] d0;
    logic [23:0] a;
    a = 24'hABCDEF;
    clear_logs();
    rd_ready = 1'b1;
    issue(a, 4'd3, to);
    n = 0;
    while (beat_data_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    rd_ready = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL bp_beat2_timeout got=0 exp=1"); end
    d0  = rd_data;
    wr0 = n_wr;
    data_moved = 1'b0; cs_rose = 1'b0; valid_fell = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_data !== d0) data_moved = 1'b1;
      if (rd_valid !== 1'b1) valid_fell = 1'b1;
      if (m_cs_n !== 1'b0) cs_rose = 1'b1;
    end
    total++;
    if (d0 !== flash_byte(a + 24'd1)) begin
      bad++;
      $display("FAIL bp_beat2_data got=%h exp=%h", d0, flash_byte(a + 24'd1));
    end
    total++;
    if (data_moved || valid_fell) begin
      bad++;
      $display("FAIL bp_stall_hold got=moved%b fell%b exp=00", data_moved, valid_fell);
    end
    total++;
    if (n_wr != wr0) begin
      bad++;
      $display("FAIL bp_stall_writes got=%0d exp=0", n_wr - wr0);
    end
    total++;
    if (cs_rose) begin bad++; $display("FAIL bp_stall_cs got=high exp=low"); end
    rd_ready = 1'b1;
    wait_idle(500, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    total++;
    if (beat_data_q.size() != 3) begin
      bad++;
      $display("FAIL bp_beats got=%0d exp=3", beat_data_q.size());
    end else begin
      total++;
      if (beat_data_q[2] !== flash_byte(a + 24'd2) || beat_last_q[2] !== 1'b1 ||
          beat_last_q[1] !== 1'b0) begin
        bad++;
        $display("FAIL bp_beat3 got=%h/%b exp=%h/1", beat_data_q[2], beat_last_q[2],
                 flash_byte(a + 24'd2));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    logic [23:0] a, b;
    a = 24'h000100;
    b = 24'h00AA00;
    clear_logs();
    rd_ready  = 1'b1;
    req_addr  = a;
    req_len   = 4'd2;
    req_valid = 1'b1;
    n = 0;
    while (acc_cyc_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    req_addr = b;
    req_len  = 4'd1;
    n = 0;
    while (acc_cyc_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    req_valid = 1'b0;
    wait_idle(1000, to);
    total++;
    if (acc_cyc_q.size() != 2 || to) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d exp=2", acc_cyc_q.size());
    end
    total++;
    if (beat_data_q.size() != 3) begin
      bad++;
      $display("FAIL b2b_beats got=%0d exp=3", beat_data_q.size());
    end else begin
      total++;
      if (acc_cyc_q.size() == 2 && acc_cyc_q[1] != beat_cyc_q[1] + 1) begin
        bad++;
        $display("FAIL b2b_gap got=%0d exp=%0d", acc_cyc_q[1], beat_cyc_q[1] + 1);
      end
      total++;
      if (beat_data_q[0] !== flash_byte(a) || beat_data_q[1] !== flash_byte(a + 24'd1) ||
          beat_data_q[2] !== flash_byte(b)) begin
        bad++;
        $display("FAIL b2b_data got=%h %h %h exp=%h %h %h", beat_data_q[0], beat_data_q[1],
                 beat_data_q[2], flash_byte(a), flash_byte(a + 24'd1), flash_byte(b));
      end
      total++;
      if ({beat_last_q[0], beat_last_q[1], beat_last_q[2]} !== 3'b011) begin
        bad++;
        $display("FAIL b2b_last got=%b%b%b exp=011", beat_last_q[0], beat_last_q[1],
                 beat_last_q[2]);
      end
    end
  endtask

  task automatic test_reset_midfetch();
    bit to;
    int n;
    logic [7:0] exp_m [6];
    exp_m[0] = 8'h03; exp_m[1] = 8'h7F; exp_m[2] = 8'hFF;
    exp_m[3] = 8'hFF; exp_m[4] = 8'hFF; exp_m[5] = 8'hFF;
    clear_logs();
    rd_ready = 1'b1;
    issue(24'h0055AA, 4'd3, to);
    n = 0;
    while (beat_data_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (m_cs_n !== 1'b0 || beat_data_q.size() != 1) begin
      bad++;
      $display("FAIL rst_mid_pre got=cs_n%b beats%0d exp=cs_n0 beats1", m_cs_n,
               beat_data_q.size());
    end
    cfg_a_q.delete();
    cfg_d_q.delete();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0 || spi_reg_write !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_flags got=%b%b%b exp=001", rd_valid, spi_reg_write, busy);
    end
    reset = 1'b0;
    wait_idle(200, to);
    total++;
    if (to || cfg_a_q.size() != 2) begin
      bad++;
      $display("FAIL rst_mid_init got=%0d exp=2", cfg_a_q.size());
    end else begin
      total++;
      if (cfg_a_q[0] !== 3'd4 || cfg_d_q[0] !== 8'h00 ||
          cfg_a_q[1] !== 3'd5 || cfg_d_q[1] !== 8'h01) begin
        bad++;
        $display("FAIL rst_mid_init_vals got=%0d/%h %0d/%h exp=4/00 5/01", cfg_a_q[0],
                 cfg_d_q[0], cfg_a_q[1], cfg_d_q[1]);
      end
    end
    total++;
    if (m_cs_n !== 1'b1 || beat_data_q.size() != 1) begin
      bad++;
      $display("FAIL rst_mid_post got=cs_n%b beats%0d exp=cs_n1 beats1", m_cs_n,
               beat_data_q.size());
    end
    clear_logs();
    issue(24'h7FFFFF, 4'd2, to);
    wait_idle(1000, to);
    total++;
    if (to || beat_data_q.size() != 2) begin
      bad++;
      $display("FAIL rst_mid_req2_beats got=%0d exp=2", beat_data_q.size());
    end else begin
      total++;
      if (beat_data_q[0] !== 8'h0C || beat_data_q[1] !== 8'hF3 ||
          beat_last_q[0] !== 1'b0 || beat_last_q[1] !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid_req2_data got=%h/%b %h/%b exp=0c/0 f3/1", beat_data_q[0],
                 beat_last_q[0], beat_data_q[1], beat_last_q[1]);
      end
    end
    total++;
    if (mosi_q.size() != 6) begin
      bad++;
      $display("FAIL rst_mid_mosi_len got=%0d exp=6", mosi_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (mosi_q[i] !== exp_m[i]) begin
          bad++;
          $display("FAIL rst_mid_mosi[%0d] got=%h exp=%h", i, mosi_q[i], exp_m[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_len16();
    test_backpressure();
    test_back_to_back();
    test_reset_midfetch();
    total++;
    if (proto_err != 0) begin
      bad++;
      $display("FAIL spi_protocol got=%0d exp=0", proto_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
